// File: rtl/i2cm_seq_pkg.sv
// rtl/i2cm_seq_pkg.sv - engine command codes, response status codes and sequencer states
// Shared by the sequencer and anything that talks to the i2cm byte engine.
package i2cm_seq_pkg;

  localparam logic [4:0] CMD_START = 5'b00001;
  localparam logic [4:0] CMD_WRITE = 5'b00010;
  localparam logic [4:0] CMD_READ  = 5'b00100;
  localparam logic [4:0] CMD_STOP  = 5'b01000;

  localparam logic [1:0] STS_OK    = 2'b00;
  localparam logic [1:0] STS_ANACK = 2'b01;
  localparam logic [1:0] STS_DNACK = 2'b10;
  localparam logic [1:0] STS_ERR   = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_ADDR, ST_REG, ST_RSTART,
    ST_RADDR, ST_WDATA, ST_RDATA, ST_STOP, ST_RESP
  } seq_state_e;

  // Engine command a state issues; the repeated START reuses CMD_START.
  function automatic logic [4:0] state_cmd(seq_state_e s);
    case (s)
      ST_START, ST_RSTART:                 return CMD_START;
      ST_ADDR, ST_REG, ST_RADDR, ST_WDATA: return CMD_WRITE;
      ST_RDATA:                            return CMD_READ;
      ST_STOP:                             return CMD_STOP;
      default:                             return 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/i2cm_seq_if.sv
// rtl/i2cm_seq_if.sv - request/response and engine command bundle for i2cm_seq
// master is the sequencer's view; slave is the requester plus byte engine.
interface i2cm_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rd;
  logic [6:0]  req_dev;
  logic [7:0]  req_reg;
  logic [2:0]  req_len;
  logic [31:0] req_wdata;
  logic        abort;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [4:0]  eng_cmds;
  logic [4:0]  eng_cdone;
  logic [7:0]  eng_tbyte;
  logic        eng_txack;
  logic        eng_rxack;
  logic [7:0]  eng_rbyte;
  logic        eng_error;

  modport master (
    input  req_valid, req_rd, req_dev, req_reg, req_len, req_wdata, abort,
           eng_cdone, eng_rxack, eng_rbyte, eng_error,
    output req_ready, rsp_valid, rsp_rdata, rsp_status,
           eng_cmds, eng_tbyte, eng_txack
  );

  modport slave (
    output req_valid, req_rd, req_dev, req_reg, req_len, req_wdata, abort,
           eng_cdone, eng_rxack, eng_rbyte, eng_error,
    input  req_ready, rsp_valid, rsp_rdata, rsp_status,
           eng_cmds, eng_tbyte, eng_txack
  );
endinterface

// File: rtl/i2cm_seq.sv
// rtl/i2cm_seq.sv - register-style I2C transaction sequencer driving the i2cm byte engine
// One request in, START/WRITE/READ/STOP commands out, one response pulse back.
module i2cm_seq
  import i2cm_seq_pkg::*;
(
  input logic       clk,
  input logic       rst_n,
  i2cm_seq_if.master bus
);

  seq_state_e  state_q, state_d;
  logic        cmd_on_q, cmd_on_d;
  logic        abort_q, abort_d;
  logic        ready_q, ready_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  len_q, len_d;
  logic        rd_q, rd_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  status_q, status_d;
  logic [31:0] rdata_q, rdata_d;

  logic [4:0]  cmd;
  logic        last;
  logic        nack_chk;
  logic [4:0]  byte_idx;

  assign cmd      = state_cmd(state_q);
  assign last     = (cnt_q == len_q - 3'd1);
  assign nack_chk = (state_q == ST_ADDR) || (state_q == ST_REG) ||
                    (state_q == ST_RADDR) || (state_q == ST_WDATA);
  assign byte_idx = {cnt_q[1:0], 3'b000};
  assign ready_d  = (state_d == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    cmd_on_d = cmd_on_q;
    abort_d  = abort_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    rd_d     = rd_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    status_d = status_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (bus.req_valid && ready_q) begin
          rd_d     = bus.req_rd;
          dev_d    = bus.req_dev;
          reg_d    = bus.req_reg;
          len_d    = (bus.req_len > 3'd4) ? 3'd4 : bus.req_len;
          wdata_d  = bus.req_wdata;
          cnt_d    = 3'd0;
          status_d = STS_OK;
          rdata_d  = 32'd0;
          cmd_on_d = 1'b1;
          state_d  = ST_START;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        abort_d = abort_q | bus.abort;
        if (bus.eng_error) begin
          cmd_on_d = 1'b0;
          status_d = STS_ERR;
          state_d  = ST_RESP;
        end else if (!cmd_on_q) begin
          // Re-raise only after a full low cycle so the engine sees a fresh command.
          cmd_on_d = 1'b1;
        end else if ((bus.eng_cdone & cmd) != 5'd0) begin
          cmd_on_d = 1'b0;
          if (state_q == ST_RDATA) rdata_d[byte_idx +: 8] = bus.eng_rbyte;
          if (nack_chk && bus.eng_rxack) begin
            status_d = ((state_q == ST_ADDR) || (state_q == ST_RADDR)) ? STS_ANACK : STS_DNACK;
            state_d  = ST_STOP;
          end else if ((abort_q | bus.abort) && (state_q != ST_STOP)) begin
            status_d = STS_ERR;
            state_d  = ST_STOP;
          end else begin
            case (state_q)
              ST_START:  state_d = ST_ADDR;
              ST_ADDR:   state_d = (len_q == 3'd0) ? ST_STOP : ST_REG;
              ST_REG: begin
                state_d = rd_q ? ST_RSTART : ST_WDATA;
                cnt_d   = 3'd0;
              end
              ST_RSTART: state_d = ST_RADDR;
              ST_RADDR: begin
                state_d = ST_RDATA;
                cnt_d   = 3'd0;
              end
              ST_WDATA, ST_RDATA: begin
                if (last) state_d = ST_STOP;
                else      cnt_d   = cnt_q + 3'd1;
              end
              default:   state_d = ST_RESP;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cmd_on_q <= 1'b0;
      abort_q  <= 1'b0;
      ready_q  <= 1'b0;
      cnt_q    <= 3'd0;
      len_q    <= 3'd0;
      rd_q     <= 1'b0;
      dev_q    <= 7'd0;
      reg_q    <= 8'd0;
      wdata_q  <= 32'd0;
      status_q <= STS_OK;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cmd_on_q <= cmd_on_d;
      abort_q  <= abort_d;
      ready_q  <= ready_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      rd_q     <= rd_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
    end
  end

  // A probe carries the requested direction in the address byte; full transactions start with a write.
  always_comb begin
    bus.eng_tbyte = 8'd0;
    case (state_q)
      ST_ADDR:  bus.eng_tbyte = {dev_q, (len_q == 3'd0) & rd_q};
      ST_REG:   bus.eng_tbyte = reg_q;
      ST_RADDR: bus.eng_tbyte = {dev_q, 1'b1};
      ST_WDATA: bus.eng_tbyte = wdata_q[byte_idx +: 8];
      default:  bus.eng_tbyte = 8'd0;
    endcase
  end

  assign bus.eng_cmds   = cmd_on_q ? cmd : 5'd0;
  assign bus.eng_txack  = (state_q == ST_RDATA) && last;
  assign bus.req_ready  = ready_q;
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_status = status_q;

endmodule

// File: tb/tb_i2cm_seq.sv
// tb/tb_i2cm_seq.sv - self-checking bench for i2cm_seq with an engine responder and transaction model
module tb_i2cm_seq;
  import i2cm_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2cm_seq_if bus();
  i2cm_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cur_txn = 0;

  typedef enum int {K_START, K_ADDR, K_REG, K_RSTART, K_RADDR, K_WDATA, K_RDATA, K_STOP} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] tbyte;
    logic       txack;
  } step_t;

  typedef struct {
    logic        rd;
    logic [6:0]  dev;
    logic [7:0]  rg;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [31:0] rbytes;
    int          nack_at;
    int          err_at;
    int          abort_at;
    bit          abort_same;
    logic [1:0]  exp_status;
    logic [31:0] exp_rdata;
    int          exp_ncmd;
  } vec_t;

  logic [4:0]  obs_cmd[$];
  logic [7:0]  obs_byte[$];
  logic        obs_txack[$];
  logic [1:0]  obs_status;
  logic [31:0] obs_rdata;

  step_t       exp_seq[$];
  logic [1:0]  exp_sts;
  logic [31:0] exp_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (txn %0d): got %0h, expected %0h", name, cur_txn, act, exp);
    end
  endtask

  function automatic step_t mk(kind_e k, logic [7:0] b, logic a);
    step_t s;
    s.kind = k; s.tbyte = b; s.txack = a;
    return s;
  endfunction

  function automatic logic [4:0] kind_cmd(kind_e k);
    case (k)
      K_START, K_RSTART: return CMD_START;
      K_RDATA:           return CMD_READ;
      K_STOP:            return CMD_STOP;
      default:           return CMD_WRITE;
    endcase
  endfunction

  function automatic vec_t mkv(logic rd, logic [6:0] dev, logic [7:0] rg, logic [2:0] len,
                               logic [31:0] wd, logic [31:0] rb, int nk, int er, int ab, bit same,
                               logic [1:0] est, logic [31:0] erd, int encmd);
    vec_t v;
    v.rd = rd; v.dev = dev; v.rg = rg; v.len = len; v.wdata = wd; v.rbytes = rb;
    v.nack_at = nk; v.err_at = er; v.abort_at = ab; v.abort_same = same;
    v.exp_status = est; v.exp_rdata = erd; v.exp_ncmd = encmd;
    return v;
  endfunction

  // Nominal command list from the request, then walk it applying NACK/abort/error outcomes.
  task automatic build_model(input vec_t v);
    int    n;
    int    i;
    int    rdn;
    kind_e k;
    n = (v.len > 3'd4) ? 4 : int'(v.len);
    exp_seq.delete();
    exp_seq.push_back(mk(K_START, 8'h00, 1'b0));
    if (n == 0) begin
      exp_seq.push_back(mk(K_ADDR, {v.dev, v.rd}, 1'b0));
    end else begin
      exp_seq.push_back(mk(K_ADDR, {v.dev, 1'b0}, 1'b0));
      exp_seq.push_back(mk(K_REG, v.rg, 1'b0));
      if (v.rd) begin
        exp_seq.push_back(mk(K_RSTART, 8'h00, 1'b0));
        exp_seq.push_back(mk(K_RADDR, {v.dev, 1'b1}, 1'b0));
        for (int j = 0; j < n; j++) exp_seq.push_back(mk(K_RDATA, 8'h00, j == n - 1));
      end else begin
        for (int j = 0; j < n; j++) exp_seq.push_back(mk(K_WDATA, v.wdata[8*j +: 8], 1'b0));
      end
    end
    exp_seq.push_back(mk(K_STOP, 8'h00, 1'b0));
    exp_sts = STS_OK;
    exp_rdata = 32'd0;
    rdn = 0;
    i = 0;
    while (i < exp_seq.size()) begin
      k = exp_seq[i].kind;
      if (i == v.err_at) begin
        exp_sts = STS_ERR;
        while (exp_seq.size() > i + 1) void'(exp_seq.pop_back());
        break;
      end
      if (k == K_STOP) break;
      if (k == K_RDATA) begin
        exp_rdata[8*rdn +: 8] = v.rbytes[8*rdn +: 8];
        rdn++;
      end
      if (kind_cmd(k) == CMD_WRITE && i == v.nack_at) begin
        exp_sts = (k == K_ADDR || k == K_RADDR) ? STS_ANACK : STS_DNACK;
        while (exp_seq.size() > i + 1) void'(exp_seq.pop_back());
        exp_seq.push_back(mk(K_STOP, 8'h00, 1'b0));
      end else if (i == v.abort_at) begin
        exp_sts = STS_ERR;
        while (exp_seq.size() > i + 1) void'(exp_seq.pop_back());
        exp_seq.push_back(mk(K_STOP, 8'h00, 1'b0));
      end
      i++;
    end
  endtask

  // Issue one request and play the byte engine until the response (or a reset at command reset_at).
  task automatic run_txn(input vec_t v, input int reset_at);
    int         idx;
    int         cyc;
    int         rdn;
    int         d;
    bit         got;
    logic [4:0] c;
    logic [7:0] b;
    logic       a;
    idx = 0; cyc = 0; rdn = 0; got = 1'b0;
    obs_cmd.delete(); obs_byte.delete(); obs_txack.delete();
    obs_status = 2'b00; obs_rdata = 32'd0;
    bus.req_valid = 1'b1; bus.req_rd = v.rd; bus.req_dev = v.dev; bus.req_reg = v.rg;
    bus.req_len = v.len; bus.req_wdata = v.wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_dev = 7'($urandom); bus.req_reg = 8'($urandom); bus.req_wdata = $urandom;
    bus.req_len = 3'($urandom); bus.req_rd = 1'($urandom);
    chk("accept_start", 32'(bus.eng_cmds), 32'(CMD_START));
    chk("accept_ready", 32'(bus.req_ready), 32'd0);
    while (!got && cyc < 400) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
        obs_status = bus.rsp_status;
        obs_rdata = bus.rsp_rdata;
        chk("ready_in_resp", 32'(bus.req_ready), 32'd0);
      end else if (bus.eng_cmds != 5'd0) begin
        c = bus.eng_cmds; b = bus.eng_tbyte; a = bus.eng_txack;
        obs_cmd.push_back(c); obs_byte.push_back(b); obs_txack.push_back(a);
        if (idx == reset_at) begin
          rst_n = 1'b0;
          @(negedge clk);
          chk("rst_cmds", 32'(bus.eng_cmds), 32'd0);
          chk("rst_ready", 32'(bus.req_ready), 32'd0);
          chk("rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_status}, 32'd0);
          chk("rst_rdata", bus.rsp_rdata, 32'd0);
          chk("rst_tx", {23'd0, bus.eng_tbyte, bus.eng_txack}, 32'd0);
          rst_n = 1'b1;
          @(negedge clk);
          chk("rst_ready_after", 32'(bus.req_ready), 32'd1);
          return;
        end
        if (idx == v.abort_at && !v.abort_same) begin
          bus.abort = 1'b1;
          @(negedge clk);
          bus.abort = 1'b0;
          cyc++;
          chk("hold_abort", {18'd0, bus.eng_cmds, bus.eng_tbyte, bus.eng_txack}, {18'd0, c, b, a});
        end
        d = $urandom_range(0, 2);
        repeat (d) begin
          @(negedge clk);
          cyc++;
          chk("hold", {18'd0, bus.eng_cmds, bus.eng_tbyte, bus.eng_txack}, {18'd0, c, b, a});
        end
        if (idx == v.err_at) begin
          bus.eng_error = 1'b1;
          @(negedge clk);
          bus.eng_error = 1'b0;
        end else begin
          bus.abort = (idx == v.abort_at) && v.abort_same;
          bus.eng_cdone = c;
          bus.eng_rxack = (idx == v.nack_at);
          bus.eng_rbyte = (c == CMD_READ && rdn < 4) ? v.rbytes[8*rdn +: 8] : 8'($urandom);
          if (c == CMD_READ) rdn++;
          @(negedge clk);
          bus.eng_cdone = 5'd0; bus.abort = 1'b0; bus.eng_rxack = 1'b0;
        end
        chk("gap", 32'(bus.eng_cmds), 32'd0);
        idx++;
        cyc++;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
    if (got) begin
      @(negedge clk);
      chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
      chk("ready_after", 32'(bus.req_ready), 32'd1);
    end
  endtask

  task automatic compare_model();
    chk("ncmd", 32'(obs_cmd.size()), 32'(exp_seq.size()));
    for (int i = 0; i < obs_cmd.size() && i < exp_seq.size(); i++) begin
      chk("cmd", 32'(obs_cmd[i]), 32'(kind_cmd(exp_seq[i].kind)));
      if (kind_cmd(exp_seq[i].kind) == CMD_WRITE) chk("tbyte", 32'(obs_byte[i]), 32'(exp_seq[i].tbyte));
      if (exp_seq[i].kind == K_RDATA) chk("txack", 32'(obs_txack[i]), 32'(exp_seq[i].txack));
    end
    chk("status", 32'(obs_status), 32'(exp_sts));
    chk("rdata", obs_rdata, exp_rdata);
  endtask

  initial begin
    vec_t tbl[13];
    vec_t v;
    bus.req_valid = 1'b0; bus.req_rd = 1'b0; bus.req_dev = 7'd0; bus.req_reg = 8'd0;
    bus.req_len = 3'd0; bus.req_wdata = 32'd0; bus.abort = 1'b0;
    bus.eng_cdone = 5'd0; bus.eng_rxack = 1'b0; bus.eng_rbyte = 8'd0; bus.eng_error = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_cmds", 32'(bus.eng_cmds), 32'd0);
    chk("reset_rsp", {29'd0, bus.rsp_valid, bus.rsp_status}, 32'd0);
    chk("reset_rdata", bus.rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

    tbl[0]  = mkv(1'b0, 7'h50, 8'h10, 3'd2, 32'h0000BEEF, 32'h0, -1, -1, -1, 1'b0, STS_OK,    32'h0,        6);
    tbl[1]  = mkv(1'b1, 7'h50, 8'h20, 3'd3, 32'h0, 32'h00332211, -1, -1, -1, 1'b0, STS_OK,    32'h00332211, 9);
    tbl[2]  = mkv(1'b0, 7'h50, 8'h10, 3'd2, 32'h1234, 32'h0,      1, -1, -1, 1'b0, STS_ANACK, 32'h0,        3);
    tbl[3]  = mkv(1'b1, 7'h50, 8'h00, 3'd0, 32'h0, 32'h0,        -1, -1, -1, 1'b0, STS_OK,    32'h0,        3);
    tbl[4]  = mkv(1'b0, 7'h50, 8'h10, 3'd3, 32'h00C0FFEE, 32'h0, -1,  4, -1, 1'b0, STS_ERR,   32'h0,        5);
    tbl[5]  = mkv(1'b0, 7'h50, 8'h10, 3'd2, 32'hBEEF, 32'h0,     -1, -1,  2, 1'b0, STS_ERR,   32'h0,        4);
    tbl[6]  = mkv(1'b0, 7'h2A, 8'h05, 3'd2, 32'h5A5A, 32'h0,      3, -1, -1, 1'b0, STS_DNACK, 32'h0,        5);
    tbl[7]  = mkv(1'b1, 7'h11, 8'h7F, 3'd7, 32'h0, 32'h44332211, -1, -1, -1, 1'b0, STS_OK,    32'h44332211, 10);
    tbl[8]  = mkv(1'b1, 7'h50, 8'h30, 3'd2, 32'h0, 32'hAABB,      4, -1, -1, 1'b0, STS_ANACK, 32'h0,        6);
    tbl[9]  = mkv(1'b0, 7'h50, 8'h40, 3'd1, 32'h99, 32'h0,        2, -1,  2, 1'b1, STS_DNACK, 32'h0,        4);
    tbl[10] = mkv(1'b1, 7'h50, 8'h50, 3'd2, 32'h0, 32'hAABB,     -1, -1,  5, 1'b1, STS_ERR,   32'h000000BB, 7);
    tbl[11] = mkv(1'b0, 7'h50, 8'h10, 3'd0, 32'h0, 32'h0,         1, -1, -1, 1'b0, STS_ANACK, 32'h0,        3);
    tbl[12] = mkv(1'b0, 7'h50, 8'h10, 3'd2, 32'hBEEF, 32'h0,     -1, -1,  0, 1'b0, STS_ERR,   32'h0,        2);

    for (int i = 0; i < 13; i++) begin
      cur_txn = i;
      build_model(tbl[i]);
      run_txn(tbl[i], -1);
      compare_model();
      chk("tbl_status", 32'(obs_status), 32'(tbl[i].exp_status));
      chk("tbl_rdata", obs_rdata, tbl[i].exp_rdata);
      chk("tbl_ncmd", 32'(obs_cmd.size()), 32'(tbl[i].exp_ncmd));
    end

    // Reset during the second RDATA byte of a 4-byte read.
    cur_txn = 100;
    v = mkv(1'b1, 7'h3C, 8'h02, 3'd4, 32'h0, 32'h44332211, -1, -1, -1, 1'b0, STS_OK, 32'h0, 0);
    run_txn(v, 6);

    for (int i = 0; i < 40; i++) begin
      cur_txn = 200 + i;
      v = mkv(1'($urandom), 7'($urandom), 8'($urandom), 3'($urandom), $urandom, $urandom,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1,
              ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1,
              1'($urandom), STS_OK, 32'h0, 0);
      build_model(v);
      run_txn(v, -1);
      compare_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
